// File: rtl/band_level_meter_pkg.sv
// Shared types and helpers for the band level meter: FSM state encoding,
// default fraction width and the saturating magnitude used on Q15 samples.
package meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_UPDATE  = 2'd2,
    S_QUANT   = 2'd3
  } state_e;

  localparam int Q_FP_DEF = 15;

  // |x| for a 32-bit two's complement value; the most negative code has no
  // positive twin, so it saturates instead of wrapping back to itself.
  function automatic logic [31:0] sat_abs(input logic [31:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    else if (x[31])         return 32'(-x);
    else                    return x;
  endfunction

endpackage

// File: rtl/band_level_meter_quantizer.sv
// Envelope to bar index: priority-encode the top set bit of env and map it to
// a roughly 6 dB/step level, clamped to LEVELS-1.
module level_quantizer #(
  parameter  int Q_FP   = 15,
  parameter  int LEVELS = 16,
  localparam int LW     = $clog2(LEVELS)
) (
  input  logic [31:0]   i_env,
  output logic [LW-1:0] o_level
);

  localparam int B = Q_FP + 1 - LEVELS;

  int msb;
  int lvl;

  always_comb begin
    msb = -1;
    for (int i = 0; i < 32; i++)
      if (i_env[i]) msb = i;
  end

  always_comb begin
    lvl = 0;
    if (msb >= B) lvl = msb - B + 1;
    if (lvl > LEVELS - 1) lvl = LEVELS - 1;
    o_level = LW'(lvl);
  end

endmodule

// File: rtl/band_level_meter.sv
// Per-band level meter: windowed peak magnitude, decaying envelope and a log
// bar index. Define METER_HOLD_EN to add the peak-hold output o_hold.
module band_level_meter
  import meter_pkg::*;
#(
  parameter  int Q_FP         = Q_FP_DEF,
  parameter  int WINDOW       = 512,
  parameter  int DECAY_SHIFT  = 4,
  parameter  int LEVELS       = 16,
  parameter  int HOLD_WINDOWS = 32,
  localparam int LW           = $clog2(LEVELS),
  localparam int CW           = $clog2(WINDOW)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_next,
  input  logic [31:0]   i_data,
  output logic [LW-1:0] o_level,
  output logic          o_valid,
  output logic          o_overrun
`ifdef METER_HOLD_EN
  ,
  output logic [LW-1:0] o_hold
`endif
);

  if (WINDOW < 2 || LEVELS > Q_FP + 1 || HOLD_WINDOWS < 1) begin : g_bad_cfg
    $error("band_level_meter: illegal parameter set");
  end

  state_e        state_q, state_d;
  logic          strobe_q, strobe_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   peak_q, peak_d;
  logic [31:0]   env_q, env_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;

  logic          fall;
  logic          win_last;
  logic [31:0]   mag;
  logic [31:0]   env_upd;
  logic [LW-1:0] q_level;

  // The biquad commits on the strobe's falling edge; sample one cycle later.
  assign fall     = strobe_q & ~i_next;
  assign win_last = (count_q == CW'(WINDOW - 1));
  assign mag      = sat_abs(i_data);
  assign env_upd  = (peak_q > env_q) ? peak_q : env_q - (env_q >> DECAY_SHIFT);

  // Quantise the envelope being written so the level lands with the S_QUANT cycle.
  level_quantizer #(.Q_FP(Q_FP), .LEVELS(LEVELS)) u_quant (
    .i_env   (env_upd),
    .o_level (q_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      strobe_q  <= 1'b0;
      count_q   <= '0;
      peak_q    <= '0;
      env_q     <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      count_q   <= count_d;
      peak_q    <= peak_d;
      env_q     <= env_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (fall) state_d = S_CAPTURE;
      S_CAPTURE: state_d = win_last ? S_UPDATE : S_IDLE;
      S_UPDATE:  state_d = S_QUANT;
      S_QUANT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    strobe_d  = i_next;
    count_d   = count_q;
    peak_d    = peak_q;
    env_d     = env_q;
    level_d   = level_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (fall & (state_q != S_IDLE));
    case (state_q)
      S_CAPTURE: begin
        if (mag > peak_q) peak_d = mag;
        count_d = win_last ? '0 : count_q + 1'b1;
      end
      S_UPDATE: begin
        env_d   = env_upd;
        peak_d  = '0;
        level_d = q_level;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_level   = level_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;

`ifdef METER_HOLD_EN
  localparam int HW = $clog2(HOLD_WINDOWS + 1);

  logic [LW-1:0] hold_q, hold_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q <= '0;
      hcnt_q <= '0;
    end else begin
      hold_q <= hold_d;
      hcnt_q <= hcnt_d;
    end
  end

  // Updated alongside o_level so o_hold and o_level change in the same cycle.
  always_comb begin
    hold_d = hold_q;
    hcnt_d = hcnt_q;
    if (state_q == S_UPDATE) begin
      if (q_level >= hold_q) begin
        hold_d = q_level;
        hcnt_d = HW'(HOLD_WINDOWS);
      end else if (hcnt_q <= HW'(1)) begin
        hold_d = hold_q - 1'b1;
        hcnt_d = HW'(HOLD_WINDOWS);
      end else begin
        hcnt_d = hcnt_q - 1'b1;
      end
    end
  end

  assign o_hold = hold_q;
`endif

endmodule
